// File: rtl/global_int_sequencer.sv
// global_int_sequencer
// Testbench-side interrupt source: a queued command sequencer that drives
// the platform global-interrupt lines with set / clear / toggle / timed-pulse
// operations, each preceded by a programmable start delay.
module global_int_sequencer #(
  parameter int NUM_INTS   = 127,
  parameter int FIFO_DEPTH = 8,
  parameter int DELAY_W    = 16,
  parameter int PULSE_W    = 8,
  parameter int LINE_W     = $clog2(NUM_INTS + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LINE_W-1:0]   cmd_line,
  input  logic [1:0]          cmd_op,
  input  logic [DELAY_W-1:0]  cmd_delay,
  input  logic [PULSE_W-1:0]  cmd_len,
  output logic [NUM_INTS-1:0] interrupts,
  output logic                cmd_err,
  output logic                busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OP_CLR    = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_PULSE  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  localparam logic [PTR_W:0]   DEPTH_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1'b1);
  localparam logic [PULSE_W-1:0] PULSE_ONE = PULSE_W'(1'b1);
  localparam logic [DELAY_W-1:0] DELAY_ONE = DELAY_W'(1'b1);
  localparam logic [LINE_W:0]  NUM_INTS_L = (LINE_W + 1)'(NUM_INTS);

  // Command queue storage (data only; validity is tracked by count_q)
  logic [LINE_W-1:0]  q_line_q  [FIFO_DEPTH];
  logic [1:0]         q_op_q    [FIFO_DEPTH];
  logic [DELAY_W-1:0] q_delay_q [FIFO_DEPTH];
  logic [PULSE_W-1:0] q_len_q   [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  logic [1:0]         state_q, state_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;

  logic [NUM_INTS-1:0] int_q, int_d;
  logic [PULSE_W-1:0]  pcnt_q [NUM_INTS];
  logic [PULSE_W-1:0]  pcnt_d [NUM_INTS];
  logic                err_q, err_d;

  logic               push_s, pop_s, apply_s, line_ok_s, any_pulse_s;
  logic [LINE_W-1:0]  head_line_s;
  logic [1:0]         head_op_s;
  logic [DELAY_W-1:0] head_delay_s;
  logic [PULSE_W-1:0] head_len_s;

  // Ready follows the registered count only, so a pop frees a slot one cycle later.
  assign cmd_ready = !reset && (count_q != DEPTH_CNT);
  assign push_s    = cmd_valid && cmd_ready;
  assign apply_s   = (state_q == ST_APPLY);
  assign pop_s     = apply_s;

  assign head_line_s  = q_line_q[rd_ptr_q];
  assign head_op_s    = q_op_q[rd_ptr_q];
  assign head_delay_s = q_delay_q[rd_ptr_q];
  assign head_len_s   = q_len_q[rd_ptr_q];
  assign line_ok_s    = ({1'b0, head_line_s} < NUM_INTS_L);

  // Capture an accepted command into the slot at the write pointer
  always_ff @(posedge clock) begin
    if (push_s) begin
      q_line_q[wr_ptr_q]  <= cmd_line;
      q_op_q[wr_ptr_q]    <= cmd_op;
      q_delay_q[wr_ptr_q] <= cmd_delay;
      q_len_q[wr_ptr_q]   <= cmd_len;
    end
  end

  // Queue occupancy next-state from simultaneous push/pop
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Queue pointers and occupancy; reset discards everything queued
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Head-of-queue sequencing: load delay, count it down, then apply
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          dcnt_d = head_delay_s;
          if (head_delay_s == '0) state_d = ST_APPLY;
          else                    state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        dcnt_d = dcnt_q - DELAY_ONE;
        if (dcnt_q == DELAY_ONE) state_d = ST_APPLY;
        else                     state_d = ST_WAIT;
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Line next-state: pulse decay everywhere, then the applied command overrides its own line
  always_comb begin
    for (int i = 0; i < NUM_INTS; i++) begin
      int_d[i]  = int_q[i];
      pcnt_d[i] = pcnt_q[i];
      if (pcnt_q[i] != '0) begin
        pcnt_d[i] = pcnt_q[i] - PULSE_ONE;
        if (pcnt_q[i] == PULSE_ONE) int_d[i] = 1'b0;
        else                        int_d[i] = int_q[i];
      end else begin
        pcnt_d[i] = '0;
      end
    end
    err_d = apply_s && !line_ok_s;
    if (apply_s && line_ok_s) begin
      case (head_op_s)
        OP_CLR: begin
          int_d[head_line_s]  = 1'b0;
          pcnt_d[head_line_s] = '0;
        end
        OP_SET: begin
          int_d[head_line_s]  = 1'b1;
          pcnt_d[head_line_s] = '0;
        end
        OP_PULSE: begin
          int_d[head_line_s]  = 1'b1;
          pcnt_d[head_line_s] = (head_len_s == '0) ? PULSE_ONE : head_len_s;
        end
        OP_TOGGLE: begin
          int_d[head_line_s]  = ~int_q[head_line_s];
          pcnt_d[head_line_s] = '0;
        end
        default: begin
          int_d[head_line_s]  = int_q[head_line_s];
          pcnt_d[head_line_s] = pcnt_q[head_line_s];
        end
      endcase
    end else begin
      err_d = apply_s && !line_ok_s;
    end
  end

  // Registered interrupt lines, pulse counters and error strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      int_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NUM_INTS; i++) pcnt_q[i] <= '0;
    end else begin
      int_q <= int_d;
      err_q <= err_d;
      for (int i = 0; i < NUM_INTS; i++) pcnt_q[i] <= pcnt_d[i];
    end
  end

  // Any line still inside a timed pulse keeps the sequencer busy
  always_comb begin
    any_pulse_s = 1'b0;
    for (int i = 0; i < NUM_INTS; i++) begin
      any_pulse_s = any_pulse_s | (pcnt_q[i] != '0);
    end
  end

  assign interrupts = int_q;
  assign cmd_err    = err_q;
  assign busy       = (count_q != '0) || (state_q != ST_IDLE) || any_pulse_s;

endmodule
